// File: rtl/dataflow_pkg.sv
// Shared types for the dataflow loop-lowering operators.
//   carry_state_t : loop-carry FSM states (init pending / inside loop)
//   gate_state_t  : loop-gate FSM states (drop head condition / pass)
//   xfer()        : valid/ready handshake helper
package dataflow_pkg;

    typedef enum logic [1:0] {
        S_INIT = 2'b00,
        S_LOOP = 2'b01
    } carry_state_t;

    typedef enum logic [1:0] {
        S_GATE_HEAD = 2'b00,
        S_GATE_PASS = 2'b01
    } gate_state_t;

    localparam int unsigned DataflowWidth = 32;

    function automatic logic xfer(input logic valid, input logic ready);
        return valid && ready;
    endfunction

endpackage

// File: rtl/dataflow_out_slot.sv
// One-entry valid/ready output register shared by the dataflow operators.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready/in_data     upstream side; in_ready = !full || out_ready
//   out_valid/out_ready/out_data  downstream side; out_valid = full
module dataflow_out_slot #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             full_q;
    logic [WIDTH-1:0] data_q;
    logic             accept;

    // Ready also when draining this cycle, so back-to-back tokens see no bubble.
    assign in_ready  = !full_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = full_q;
    assign out_data  = data_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (accept) begin
            // A simultaneous drain and load keeps the slot full with new data.
            full_q <= 1'b1;
            data_q <= in_data;
        end else if (out_ready) begin
            full_q <= 1'b0;
        end
    end

endmodule

// File: rtl/dataflow_carry.sv
// Loop-carried value generator placed at every loop header.
// Emits the init value (a) once, then one back-edge value (b) per true loop
// condition (d); a false condition re-arms it for the next init value.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   d_valid/d_ready/d_data    loop-condition token (1 = iterate, 0 = exit)
//   a_valid/a_ready/a_data    init-value token
//   b_valid/b_ready/b_data    back-edge value token
//   o_valid/o_ready/o_data    carried value output (one-entry slot)
module dataflow_carry
    import dataflow_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_valid,
    output logic             d_ready,
    input  logic             d_data,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [WIDTH-1:0] a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [WIDTH-1:0] b_data,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_data
);

    carry_state_t     state_q, state_d;
    logic             slot_free;
    logic             load;
    logic             sel_b;
    logic [WIDTH-1:0] load_data;
    logic             iter_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // A true condition is only taken together with its back-edge partner.
    assign iter_ok = b_valid && slot_free;

    always_comb begin
        state_d = state_q;
        a_ready = 1'b0;
        d_ready = 1'b0;
        b_ready = 1'b0;
        load    = 1'b0;
        sel_b   = 1'b0;
        unique case (state_q)
            S_INIT: begin
                a_ready = slot_free;
                if (xfer(a_valid, slot_free)) begin
                    load    = 1'b1;
                    state_d = S_LOOP;
                end
            end
            S_LOOP: begin
                // Gated by d_valid so a floating d_data cannot reach the readys.
                if (d_valid) begin
                    if (d_data) begin
                        d_ready = iter_ok;
                        b_ready = iter_ok;
                        if (iter_ok) begin
                            load  = 1'b1;
                            sel_b = 1'b1;
                        end
                    end else begin
                        // Exit needs no slot space: it emits nothing.
                        d_ready = 1'b1;
                        state_d = S_INIT;
                    end
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    assign load_data = sel_b ? b_data : a_data;

    dataflow_out_slot #(
        .WIDTH (WIDTH)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (load),
        .in_ready  (slot_free),
        .in_data   (load_data),
        .out_valid (o_valid),
        .out_ready (o_ready),
        .out_data  (o_data)
    );

endmodule

// File: tb/tb_dataflow_carry.sv
// Self-checking bench for dataflow_carry: directed scenarios with literal
// expectations, then randomized loops compared against a program-order model.
module tb_dataflow_carry;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         d_valid, d_ready, d_data;
    logic         a_valid, a_ready;
    logic [W-1:0] a_data;
    logic         b_valid, b_ready;
    logic [W-1:0] b_data;
    logic         o_valid, o_ready;
    logic [W-1:0] o_data;

    dataflow_carry #(
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .d_valid (d_valid),
        .d_ready (d_ready),
        .d_data  (d_data),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_data  (b_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model / compare process ----------------
    bit          mode_loop;  // model: init consumed, waiting for exit condition
    bit          pend;
    logic [31:0] pend_val;
    bit          hold;
    logic [31:0] hold_val;
    bit          slot_free;
    bit          xa, xd, xb, xo;
    int          n_in;
    int          n_out;
    bit          rand_phase;
    logic [31:0] o_log[$];
    logic [31:0] exp_q[$];

    initial begin
        mode_loop  = 0;
        pend       = 0;
        hold       = 0;
        n_in       = 0;
        n_out      = 0;
        rand_phase = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_o_valid", o_valid, 0);
                mode_loop = 0;
                pend      = 0;
                hold      = 0;
                n_in      = 0;
                n_out     = 0;
            end else begin
                slot_free = !o_valid || o_ready;
                if (pend) begin
                    check("latency_valid", o_valid, 1);
                    check("latency_data", o_data, pend_val);
                end else if (hold) begin
                    check("o_stable_valid", o_valid, 1);
                    check("o_stable_data", o_data, hold_val);
                end
                if (mode_loop) begin
                    check("loop_a_ready", a_ready, 0);
                    if (!d_valid) begin
                        check("loop_b_no_d", b_ready, 0);
                    end else if (!d_data) begin
                        check("exit_d_ready", d_ready, 1);
                        check("exit_b_ready", b_ready, 0);
                    end else begin
                        check("iter_d_ready", d_ready, b_valid && slot_free);
                        check("iter_b_ready", b_ready, b_valid && slot_free);
                    end
                end else begin
                    check("init_a_ready", a_ready, slot_free);
                    check("init_d_ready", d_ready, 0);
                    check("init_b_ready", b_ready, 0);
                end
                xa = a_valid && a_ready;
                xd = d_valid && d_ready;
                xb = b_valid && b_ready;
                xo = o_valid && o_ready;
                pend     = xa || xb;
                pend_val = xa ? a_data : b_data;
                hold     = o_valid && !o_ready;
                hold_val = o_data;
                if (xa) begin
                    mode_loop = 1;
                    n_in++;
                end
                if (xd && d_data) n_in++;
                if (xd && !d_data) mode_loop = 0;
                if (xo) begin
                    n_out++;
                    o_log.push_back(o_data);
                    if (rand_phase) begin
                        check("rand_exp_avail", exp_q.size() > 0, 1);
                        if (exp_q.size() > 0) check("rand_order", o_data, exp_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers (start at posedge+1) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic send_a(input logic [31:0] v);
        a_valid = 1;
        a_data  = v;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (a_ready) begin
                tick();
                a_valid = 0;
                return;
            end
            tick();
        end
        check("send_a_timeout", a_ready, 1);
        a_valid = 0;
    endtask

    task automatic send_d(input bit c, input logic [31:0] bv);
        d_valid = 1;
        d_data  = c;
        if (c) begin
            b_valid = 1;
            b_data  = bv;
        end
        for (int i = 0; i < 20; i++) begin
            #1;
            if (d_ready) begin
                tick();
                d_valid = 0;
                b_valid = 0;
                d_data  = 1'($urandom_range(0, 1));
                return;
            end
            tick();
        end
        check("send_d_timeout", d_ready, 1);
        d_valid = 0;
        b_valid = 0;
    endtask

    task automatic drain();
        o_ready = 1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (!o_valid) begin
                tick();
                return;
            end
            tick();
        end
        check("drain_timeout", o_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    int          in0, out0, total;
    logic [31:0] aq[$];
    bit          dq[$];
    logic [31:0] bq[$];
    bit          ta, td, tb;

    initial begin
        rst     = 1;
        d_valid = 0;
        d_data  = 0;
        a_valid = 0;
        a_data  = 0;
        b_valid = 0;
        b_data  = 0;
        o_ready = 0;
        #2;
        check("rst_o_valid_lit", o_valid, 0);
        check("rst_o_data", o_data, 0);
        check("rst_a_ready", a_ready, 1);
        check("rst_d_ready", d_ready, 0);
        check("rst_b_ready", b_ready, 0);
        tick();
        rst = 0;

        // 1: single init value, one-cycle latency, a blocked inside the loop
        o_ready = 1;
        a_valid = 1;
        a_data  = 5;
        settle();
        check("t1_a_ready", a_ready, 1);
        tick();
        a_valid = 0;
        settle();
        check("t1_o_valid", o_valid, 1);
        check("t1_o_data", o_data, 5);
        check("t1_a_ready_loop", a_ready, 0);
        tick();
        send_d(0, 0);
        drain();

        // 2: loop of three iterations then a new init
        o_log.delete();
        in0  = n_in;
        out0 = n_out;
        send_a(1);
        send_d(1, 2);
        send_d(1, 3);
        send_d(0, 0);
        send_a(9);
        send_d(0, 0);
        drain();
        check("t2_count", o_log.size(), 4);
        check("t2_o0", o_log[0], 1);
        check("t2_o1", o_log[1], 2);
        check("t2_o2", o_log[2], 3);
        check("t2_o3", o_log[3], 9);
        check("t2_ins", n_in - in0, 4);
        check("t2_tokens", n_out - out0, n_in - in0);

        // 3: backpressure with an iteration pending
        o_ready = 0;
        send_a(20);
        d_valid = 1;
        d_data  = 1;
        b_valid = 1;
        b_data  = 7;
        for (int i = 0; i < 4; i++) begin
            settle();
            check("t3_d_ready_bp", d_ready, 0);
            check("t3_b_ready_bp", b_ready, 0);
            check("t3_o_held", o_data, 20);
            tick();
        end
        o_ready = 1;
        settle();
        check("t3_d_ready_rel", d_ready, 1);
        check("t3_b_ready_rel", b_ready, 1);
        tick();
        d_valid = 0;
        b_valid = 0;
        settle();
        check("t3_o_valid", o_valid, 1);
        check("t3_o_data", o_data, 7);
        tick();
        send_d(0, 0);
        drain();

        // 4: true condition waits for its back-edge partner
        o_ready = 1;
        send_a(30);
        d_valid = 1;
        d_data  = 1;
        b_valid = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t4_d_wait", d_ready, 0);
            tick();
        end
        b_valid = 1;
        b_data  = 4;
        settle();
        check("t4_d_ready", d_ready, 1);
        check("t4_b_ready", b_ready, 1);
        tick();
        d_valid = 0;
        b_valid = 0;
        settle();
        check("t4_o_data", o_data, 4);
        tick();
        send_d(0, 0);
        drain();

        // 5: loop exit while the slot is full and stalled
        o_ready = 0;
        send_a(40);
        d_valid = 1;
        d_data  = 0;
        b_valid = 1;
        b_data  = 77;
        settle();
        check("t5_d_ready", d_ready, 1);
        check("t5_b_ready", b_ready, 0);
        tick();
        d_valid = 0;
        b_valid = 0;
        settle();
        check("t5_o_valid", o_valid, 1);
        check("t5_o_data", o_data, 40);
        check("t5_d_ready_init", d_ready, 0);
        a_valid = 1;
        a_data  = 41;
        settle();
        check("t5_a_ready_full", a_ready, 0);
        o_ready = 1;
        settle();
        check("t5_a_ready_drain", a_ready, 1);
        tick();
        a_valid = 0;
        settle();
        check("t5_o_data_new", o_data, 41);
        tick();
        send_d(0, 0);
        drain();

        // 6: asynchronous reset mid-loop with the slot full
        o_ready = 0;
        send_a(50);
        settle();
        check("t6_full", o_valid, 1);
        rst = 1;
        #1;
        check("t6_rst_o_valid", o_valid, 0);
        check("t6_rst_o_data", o_data, 0);
        check("t6_rst_a_ready", a_ready, 1);
        check("t6_rst_d_ready", d_ready, 0);
        check("t6_rst_b_ready", b_ready, 0);
        d_valid = 1;
        d_data  = 1;
        b_valid = 1;
        b_data  = 66;
        a_valid = 1;
        a_data  = 67;
        tick();
        tick();
        settle();
        check("t6_rst_hold_valid", o_valid, 0);
        d_valid = 0;
        b_valid = 0;
        a_valid = 0;
        tick();
        rst     = 0;
        o_ready = 1;
        send_a(8);
        settle();
        check("t6_o_valid", o_valid, 1);
        check("t6_o_data", o_data, 8);
        tick();
        send_d(0, 0);
        drain();

        // Randomized loops against program order
        exp_q.delete();
        for (int l = 0; l < 30; l++) begin
            int unsigned n;
            logic [31:0] v;
            n = $urandom_range(0, 4);
            v = $urandom;
            aq.push_back(v);
            exp_q.push_back(v);
            for (int i = 0; i < int'(n); i++) begin
                v = $urandom;
                dq.push_back(1'b1);
                bq.push_back(v);
                exp_q.push_back(v);
            end
            dq.push_back(1'b0);
        end
        total      = exp_q.size();
        in0        = n_in;
        out0       = n_out;
        rand_phase = 1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (aq.size() == 0 && dq.size() == 0 && bq.size() == 0 && exp_q.size() == 0) break;
            if (aq.size() > 0 && !a_valid && $urandom_range(0, 3) != 0) begin
                a_valid = 1;
                a_data  = aq[0];
            end
            if (dq.size() > 0 && !d_valid && $urandom_range(0, 3) != 0) begin
                d_valid = 1;
                d_data  = dq[0];
            end
            if (!d_valid) d_data = 1'($urandom_range(0, 1));
            if (bq.size() > 0 && !b_valid && $urandom_range(0, 3) != 0) begin
                b_valid = 1;
                b_data  = bq[0];
            end
            o_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            ta = a_valid && a_ready;
            td = d_valid && d_ready;
            tb = b_valid && b_ready;
            tick();
            if (ta) begin
                void'(aq.pop_front());
                a_valid = 0;
            end
            if (td) begin
                void'(dq.pop_front());
                d_valid = 0;
            end
            if (tb) begin
                void'(bq.pop_front());
                b_valid = 0;
            end
        end
        check("rand_budget", exp_q.size(), 0);
        check("rand_out_count", n_out - out0, total);
        check("rand_tokens", n_out - out0, n_in - in0);
        rand_phase = 0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
